// File: rtl/rv_fetch_queue_if.sv
// Fetch-queue port bundle: instruction-bus request/ack, redirect, and decode-side handshake.
// The master modport is the queue itself; the slave modport is the bus + decode environment.
interface rv_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(2 * DEPTH) + 1;

  logic          i_flush;
  logic [31:0]   i_flush_pc;
  logic          o_cyc;
  logic [31:0]   o_addr;
  logic          i_ack;
  logic [31:0]   i_instruction;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_instruction;
  logic          o_compressed;
  logic [31:0]   o_pc;
  logic [LW-1:0] o_level;

  modport master (
    input  i_flush, i_flush_pc, i_ack, i_instruction, i_ready,
    output o_cyc, o_addr, o_valid, o_instruction, o_compressed, o_pc, o_level
  );

  modport slave (
    output i_flush, i_flush_pc, i_ack, i_instruction, i_ready,
    input  o_cyc, o_addr, o_valid, o_instruction, o_compressed, o_pc, o_level
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// Prefetch queue of DEPTH words held as 2*DEPTH halfword slots; reassembles mixed 16/32-bit
// instructions across word boundaries and presents one per cycle with its PC.
//
// state   | meaning
// S_IDLE  | no request on the bus
// S_BUSY  | request outstanding, its data will be written
// S_STALE | request outstanding but issued before a redirect; its ack is dropped
module rv_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          SUPPORT_C = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  rv_fetch_queue_if.master fq
);

  localparam int SLOTS = 2 * DEPTH;
  localparam int PW    = $clog2(SLOTS);
  localparam int LW    = PW + 1;
  localparam logic [LW-1:0] LAUNCH_MAX = LW'(SLOTS - 2);
  localparam logic [31:0]   PC_MASK    = SUPPORT_C ? 32'hFFFF_FFFF : 32'hFFFF_FFFD;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_STALE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [SLOTS];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level, level_nxt, push_cnt, pop_cnt;
  logic [31:0]   head_pc, fetch_addr, req_addr, fetch_src, flush_word;
  logic          drop;
  logic [15:0]   hw0, hw1;
  logic          is32, head_ok, push, pop, launch, launch_ok;

  // Head decode straight from the slot array
  always_comb begin
    hw0     = mem[rd_ptr];
    hw1     = mem[rd_ptr + PW'(1)];
    is32    = !SUPPORT_C || (hw0[1:0] == 2'b11);
    head_ok = is32 ? (level >= LW'(2)) : (level != '0);
  end

  always_comb begin
    push_cnt   = push ? (drop ? LW'(1) : LW'(2)) : '0;
    pop_cnt    = pop ? (is32 ? LW'(2) : LW'(1)) : '0;
    level_nxt  = fq.i_flush ? '0 : level + push_cnt - pop_cnt;
    launch_ok  = level_nxt <= LAUNCH_MAX;
    flush_word = {fq.i_flush_pc[31:2], 2'b00};
    fetch_src  = fq.i_flush ? flush_word : fetch_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch_ok) begin
          state_nxt = S_BUSY;
          launch    = 1'b1;
        end
      end
      S_BUSY, S_STALE: begin
        if (fq.i_ack) begin
          state_nxt = launch_ok ? S_BUSY : S_IDLE;
          launch    = launch_ok;
        end else if (fq.i_flush) begin
          state_nxt = S_STALE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A redirect suppresses both the head and any write in the same cycle
  always_comb begin
    fq.o_cyc   = (state != S_IDLE);
    fq.o_valid = head_ok & ~fq.i_flush;
    push       = (state == S_BUSY) & fq.i_ack & ~fq.i_flush;
    pop        = fq.o_valid & fq.i_ready;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      head_pc    <= RESET_PC & PC_MASK;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      req_addr   <= {RESET_PC[31:2], 2'b00};
      drop       <= SUPPORT_C & RESET_PC[1];
    end else begin
      level <= level_nxt;
      if (launch) begin
        req_addr   <= fetch_src;
        fetch_addr <= fetch_src + 32'd4;
      end else begin
        fetch_addr <= fetch_src;
      end
      if (fq.i_flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        head_pc <= fq.i_flush_pc & PC_MASK;
        drop    <= SUPPORT_C & fq.i_flush_pc[1];
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + (drop ? PW'(1) : PW'(2));
          drop   <= 1'b0;
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + (is32 ? PW'(2) : PW'(1));
          head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      if (drop) begin
        mem[wr_ptr] <= fq.i_instruction[31:16];
      end else begin
        mem[wr_ptr]            <= fq.i_instruction[15:0];
        mem[wr_ptr + PW'(1)]   <= fq.i_instruction[31:16];
      end
    end
  end

  assign fq.o_addr        = req_addr;
  assign fq.o_pc          = head_pc;
  assign fq.o_level       = level;
  assign fq.o_compressed  = ~is32;
  assign fq.o_instruction = is32 ? {hw1, hw0} : {16'h0000, hw0};

endmodule
